// File: rtl/router_pkt_tx.sv
// -----------------------------------------------------------------------------
// router_pkt_tx
// Packet source for one input port of the 1x3 router. A command (destination
// address, payload length, parity-corruption flag) is accepted in IDLE, the
// full payload is buffered in LOAD, and the packet is then streamed as header,
// payload bytes and a trailing parity byte under the router's busy flow
// control. A fixed number of idle cycles follows each packet. Rising edges of
// the router's error flag are counted with saturation.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_addr, cmd_len     destination port (0..2) and payload length (1..MAX_LEN)
//   cmd_bad_parity        1 = flip bit0 of the transmitted parity byte
//   pl_valid/pl_ready     payload byte handshake (ready only in LOAD)
//   pl_data               payload byte
//   busy                  router busy; a byte is consumed at an edge with busy=0
//   router_err            router parity error flag
//   pkt_valid, data_out   registered byte stream to the router
//   pkt_done              one-cycle pulse after the parity byte is consumed
//   bad_cmd               one-cycle pulse when an illegal command is dropped
//   err_count             saturating count of router_err rising edges
// -----------------------------------------------------------------------------
module router_pkt_tx #(
    parameter int MAX_LEN    = 63,
    parameter int GAP_CYCLES = 2,
    parameter int ERRW       = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_addr,
    input  logic [5:0]      cmd_len,
    input  logic            cmd_bad_parity,
    input  logic            pl_valid,
    output logic            pl_ready,
    input  logic [7:0]      pl_data,
    input  logic            busy,
    input  logic            router_err,
    output logic            pkt_valid,
    output logic [7:0]      data_out,
    output logic            pkt_done,
    output logic            bad_cmd,
    output logic [ERRW-1:0] err_count
);

    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_HEADER  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_PARITY  = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      addr_q, addr_d;
    logic [5:0]      len_q, len_d;
    logic            badpar_q, badpar_d;
    logic [5:0]      wr_ptr_q, wr_ptr_d;
    logic [5:0]      rd_ptr_q, rd_ptr_d;
    logic [7:0]      parity_q, parity_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic            badcmd_q, badcmd_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;
    logic            err_prev_q;
    logic [7:0]      buf_q [0:MAX_LEN-1];

    logic cmd_accept_s, cmd_illegal_s, pl_store_s, last_store_s;
    logic consume_s, last_payload_s, gap_done_s, wr_en_s, err_rise_s;
    logic [7:0] rd_byte_s;

    assign cmd_ready      = (state_q == S_IDLE);
    assign pl_ready       = (state_q == S_LOAD);
    assign cmd_accept_s   = cmd_valid & cmd_ready;
    assign cmd_illegal_s  = (cmd_len == 6'd0) || (cmd_addr == 2'd3) || (32'(cmd_len) > MAX_LEN);
    assign pl_store_s     = pl_valid & pl_ready;
    assign last_store_s   = pl_store_s && (wr_ptr_q == (len_q - 6'd1));
    assign consume_s      = ~busy;
    // rd_ptr always points at the byte that follows the one currently driven
    assign last_payload_s = (rd_ptr_q == len_q);
    assign rd_byte_s      = buf_q[rd_ptr_q];
    assign gap_done_s     = ((32'(gap_q) + 32'd1) >= GAP_CYCLES);
    assign err_rise_s     = router_err & ~err_prev_q;

    assign pkt_valid = valid_q;
    assign data_out  = data_q;
    assign pkt_done  = done_q;
    assign bad_cmd   = badcmd_q;
    assign err_count = err_cnt_q;

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (cmd_accept_s && !cmd_illegal_s) state_d = S_LOAD;   else state_d = state_q;
            S_LOAD:    if (last_store_s)                   state_d = S_HEADER; else state_d = state_q;
            S_HEADER:  if (consume_s)                      state_d = S_PAYLOAD; else state_d = state_q;
            S_PAYLOAD: if (consume_s && last_payload_s)    state_d = S_PARITY; else state_d = state_q;
            S_PARITY:  if (consume_s) state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP; else state_d = state_q;
            S_GAP:     if (gap_done_s)                     state_d = S_IDLE;   else state_d = state_q;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM output / datapath next values
    always_comb begin
        addr_d   = addr_q;
        len_d    = len_q;
        badpar_d = badpar_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        parity_d = parity_q;
        data_d   = data_q;
        valid_d  = valid_q;
        gap_d    = gap_q;
        done_d   = 1'b0;
        badcmd_d = 1'b0;
        wr_en_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_accept_s) begin
                    addr_d   = cmd_addr;
                    len_d    = cmd_len;
                    badpar_d = cmd_bad_parity;
                    wr_ptr_d = 6'd0;
                    badcmd_d = cmd_illegal_s;
                end else begin
                    badcmd_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (pl_store_s) begin
                    wr_en_s  = 1'b1;
                    wr_ptr_d = wr_ptr_q + 6'd1;
                    if (last_store_s) begin
                        data_d   = {len_q, addr_q};
                        parity_d = {len_q, addr_q};
                        valid_d  = 1'b1;
                        rd_ptr_d = 6'd0;
                    end else begin
                        valid_d = 1'b0;
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            S_HEADER, S_PAYLOAD: begin
                if (consume_s) begin
                    if ((state_q == S_PAYLOAD) && last_payload_s) begin
                        // parity already holds header ^ every payload byte
                        data_d  = parity_q ^ {7'd0, badpar_q};
                        valid_d = 1'b0;
                    end else begin
                        data_d   = rd_byte_s;
                        parity_d = parity_q ^ rd_byte_s;
                        rd_ptr_d = rd_ptr_q + 6'd1;
                    end
                end else begin
                    data_d = data_q;
                end
            end
            S_PARITY: begin
                if (consume_s) begin
                    data_d = 8'd0;
                    done_d = 1'b1;
                    gap_d  = '0;
                end else begin
                    done_d = 1'b0;
                end
            end
            S_GAP: begin
                gap_d = gap_q + GW'(1);
            end
            default: begin
                data_d  = 8'd0;
                valid_d = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q   <= 2'd0;
            len_q    <= 6'd0;
            badpar_q <= 1'b0;
            wr_ptr_q <= 6'd0;
            rd_ptr_q <= 6'd0;
            parity_q <= 8'd0;
            data_q   <= 8'd0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            badcmd_q <= 1'b0;
            gap_q    <= '0;
        end else begin
            addr_q   <= addr_d;
            len_q    <= len_d;
            badpar_q <= badpar_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            parity_q <= parity_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            badcmd_q <= badcmd_d;
            gap_q    <= gap_d;
        end
    end

    // Payload buffer storage (plain memory, contents are don't-care after reset)
    always_ff @(posedge clock) begin
        if (wr_en_s) buf_q[wr_ptr_q] <= pl_data;
    end

    // Saturating router error edge count next value
    always_comb begin
        if (err_rise_s && (err_cnt_q != {ERRW{1'b1}})) err_cnt_d = err_cnt_q + ERRW'(1);
        else                                           err_cnt_d = err_cnt_q;
    end

    // Router error edge detector and counter registers (active in every state)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_prev_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            err_prev_q <= router_err;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_bad_parity;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       pl_valid, pl_ready;
    logic [7:0] pl_data;
    logic       busy, router_err;
    logic       pkt_valid, pkt_done, bad_cmd;
    logic [7:0] data_out;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    router_pkt_tx #(.MAX_LEN(63), .GAP_CYCLES(2), .ERRW(8)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_bad_parity(cmd_bad_parity),
        .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
        .busy(busy), .router_err(router_err),
        .pkt_valid(pkt_valid), .data_out(data_out), .pkt_done(pkt_done),
        .bad_cmd(bad_cmd), .err_count(err_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic pv, input logic [7:0] d);
        check_eq({tag, "_pv"},   32'(pkt_valid), 32'(pv));
        check_eq({tag, "_data"}, 32'(data_out),  32'(d));
    endtask

    task automatic issue_cmd(input logic [1:0] a, input logic [5:0] l, input logic bp);
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_bad_parity = bp;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic load_byte(input logic [7:0] d);
        pl_valid = 1'b1; pl_data = d;
        step();
        pl_valid = 1'b0;
    endtask

    // Called on the sample where pkt_done is high; counts idle samples until cmd_ready
    task automatic check_gap(input string tag);
        int idle;
        idle = 0;
        while (cmd_ready == 1'b0 && idle < 10) begin
            expect_out({tag, "_idle"}, 1'b0, 8'h00);
            idle++;
            step();
        end
        check_eq({tag, "_gap_len"}, 32'(idle), 32'd2);
    endtask

    task automatic run_packet(input logic [1:0] a, input logic [5:0] l, input int seed);
        logic [7:0] b;
        logic [7:0] par;
        issue_cmd(a, l, 1'b0);
        par = {l, a};
        for (int i = 0; i < int'(l); i++) begin
            b = 8'(i * 5 + seed);
            load_byte(b);
        end
        expect_out("p_hdr", 1'b1, {l, a});
        for (int i = 0; i < int'(l); i++) begin
            step();
            b = 8'(i * 5 + seed);
            par = par ^ b;
            expect_out("p_byte", 1'b1, b);
        end
        step();
        expect_out("p_par", 1'b0, par);
        step();
        check_eq("p_done", 32'(pkt_done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = 2'd0; cmd_len = 6'd0; cmd_bad_parity = 1'b0;
        pl_valid = 1'b0; pl_data = 8'd0; busy = 1'b0; router_err = 1'b0;
        step(); step();
        check_eq("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        check_eq("rst_data_out",  32'(data_out),  32'd0);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_pl_ready",  32'(pl_ready),  32'd0);
        check_eq("rst_err_count", 32'(err_count), 32'd0);
        reset = 1'b0;
        step();

        // Test 1: addr=1 len=3, no backpressure
        issue_cmd(2'd1, 6'd3, 1'b0);
        check_eq("t1_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("t1_pl_ready",  32'(pl_ready),  32'd1);
        load_byte(8'h11); load_byte(8'h22); load_byte(8'h33);
        expect_out("t1_hdr", 1'b1, 8'h0D);
        step(); expect_out("t1_b0", 1'b1, 8'h11);
        step(); expect_out("t1_b1", 1'b1, 8'h22);
        step(); expect_out("t1_b2", 1'b1, 8'h33);
        step(); expect_out("t1_par", 1'b0, 8'h0D);
        check_eq("t1_done_early", 32'(pkt_done), 32'd0);
        step(); check_eq("t1_done", 32'(pkt_done), 32'd1);
        expect_out("t1_after", 1'b0, 8'h00);
        step(); check_eq("t1_done_once", 32'(pkt_done), 32'd0);
        check_eq("t1_gap_busy", 32'(cmd_ready), 32'd0);
        step(); check_eq("t1_idle_ready", 32'(cmd_ready), 32'd1);

        // Test 2: busy held for 3 cycles after the header
        issue_cmd(2'd1, 6'd3, 1'b0);
        load_byte(8'h11); load_byte(8'h22); load_byte(8'h33);
        expect_out("t2_hdr1", 1'b1, 8'h0D);
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); expect_out("t2_hdr_hold", 1'b1, 8'h0D);
        end
        busy = 1'b0;
        step(); expect_out("t2_b0", 1'b1, 8'h11);
        step(); expect_out("t2_b1", 1'b1, 8'h22);
        step(); expect_out("t2_b2", 1'b1, 8'h33);
        step(); expect_out("t2_par", 1'b0, 8'h0D);
        busy = 1'b1;
        step(); expect_out("t2_par_hold", 1'b0, 8'h0D);
        check_eq("t2_no_done", 32'(pkt_done), 32'd0);
        busy = 1'b0;
        step(); check_eq("t2_done", 32'(pkt_done), 32'd1);
        check_gap("t2");

        // Test 3: corrupted parity bit, then one router_err pulse
        issue_cmd(2'd1, 6'd3, 1'b1);
        load_byte(8'h11); load_byte(8'h22); load_byte(8'h33);
        expect_out("t3_hdr", 1'b1, 8'h0D);
        step(); step(); step();
        expect_out("t3_b2", 1'b1, 8'h33);
        step(); expect_out("t3_par", 1'b0, 8'h0C);
        step(); check_eq("t3_done", 32'(pkt_done), 32'd1);
        check_gap("t3");
        router_err = 1'b1; step(); router_err = 1'b0; step();
        check_eq("t3_err_count", 32'(err_count), 32'd1);
        step();
        check_eq("t3_err_level_once", 32'(err_count), 32'd1);

        // Test 4: illegal commands are dropped
        issue_cmd(2'd0, 6'd0, 1'b0);
        check_eq("t4_bad_len", 32'(bad_cmd), 32'd1);
        check_eq("t4_ready_a", 32'(cmd_ready), 32'd1);
        expect_out("t4_out_a", 1'b0, 8'h00);
        step(); check_eq("t4_bad_pulse", 32'(bad_cmd), 32'd0);
        issue_cmd(2'd3, 6'd5, 1'b0);
        check_eq("t4_bad_addr", 32'(bad_cmd), 32'd1);
        check_eq("t4_ready_b", 32'(cmd_ready), 32'd1);
        check_eq("t4_pl_ready", 32'(pl_ready), 32'd0);
        step(); check_eq("t4_bad_pulse2", 32'(bad_cmd), 32'd0);
        expect_out("t4_out_b", 1'b0, 8'h00);

        // Test 5: reset in the middle of the payload
        issue_cmd(2'd2, 6'd10, 1'b0);
        for (int i = 0; i < 10; i++) load_byte(8'(8'hA0 + i));
        expect_out("t5_hdr", 1'b1, 8'h2A);
        for (int i = 0; i < 4; i++) begin
            step(); expect_out("t5_byte", 1'b1, 8'(8'hA0 + i));
        end
        #2 reset = 1'b1;
        #1;
        expect_out("t5_async_rst", 1'b0, 8'h00);
        check_eq("t5_rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("t5_rst_err", 32'(err_count), 32'd0);
        step();
        reset = 1'b0;
        step();
        expect_out("t5_post_rst", 1'b0, 8'h00);
        issue_cmd(2'd0, 6'd1, 1'b0);
        load_byte(8'h5A);
        expect_out("t5_hdr2", 1'b1, 8'h04);
        step(); expect_out("t5_b0", 1'b1, 8'h5A);
        step(); expect_out("t5_par", 1'b0, 8'h5E);
        step(); check_eq("t5_done", 32'(pkt_done), 32'd1);
        check_gap("t5");

        // Test 6: saturating error count, then back-to-back max-length packets
        for (int i = 0; i < 300; i++) begin
            router_err = 1'b1; step();
            router_err = 1'b0; step();
        end
        check_eq("t6_err_sat", 32'(err_count), 32'hFF);
        run_packet(2'd2, 6'd63, 7);
        check_gap("t6a");
        run_packet(2'd0, 6'd63, 200);
        check_gap("t6b");
        check_eq("t6_err_hold", 32'(err_count), 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
